// File: rtl/inst_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: format codes,
// loader states and the RV32I opcodes the boot path emits.
package inst_encoder_loader_pkg;

    // Same encoding as the CPU extender's immSrc select.
    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_R = 2'b01,
        FMT_S = 2'b10,
        FMT_B = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/inst_encoder_loader_pack.sv
// Packs decoded instruction fields into an RV32I word and reports whether
// the immediate is representable in the selected format.
module inst_pack
    import inst_encoder_loader_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        imm_ok
);

    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    always_comb begin
        word   = '0;
        imm_ok = 1'b1;
        unique case (fmt_e'(fmt))
            FMT_I: begin
                word   = {imm[11:0], rs1, funct3, rd, opcode};
                imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
            end
            FMT_R: begin
                word   = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_S: begin
                word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
            end
            FMT_B: begin
                // Branch offsets are even; bit 0 has no slot in the word.
                word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                imm_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            end
            default: begin
                word   = '0;
                imm_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Boot-path loader: accepts field bundles, encodes them and writes the words
// sequentially into instruction memory with a write/ack handshake.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

    state_e      state_q, state_d;
    logic [31:0] packed_word;
    logic        imm_ok;
    logic        handshake;
    logic        write_done;

    inst_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm),
        .word   (packed_word),
        .imm_ok (imm_ok)
    );

    // Held low while reset is asserted so nothing is offered before release.
    assign in_ready   = rst_n && (state_q == ST_IDLE);
    assign mem_we     = (state_q == ST_WRITE);
    assign full       = (state_q == ST_FULL);
    assign handshake  = in_valid && in_ready;
    assign write_done = (state_q == ST_WRITE) && mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (handshake && imm_ok) state_d = ST_WRITE;
                ST_WRITE: if (mem_ack) state_d = (word_count == LAST_COUNT) ? ST_FULL : ST_IDLE;
                ST_FULL:  state_d = ST_FULL;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            err        <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else if (clear) begin
            mem_addr   <= BASE_ADDR;
            err        <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            if (handshake) begin
                if (imm_ok) begin
                    mem_wdata <= packed_word;
                end else begin
                    // Rejected bundle is consumed; the counter saturates.
                    err <= 1'b1;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
            end
            if (write_done) begin
                mem_addr   <= mem_addr + 1'b1;
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader: directed cases from the bring-up
// list plus randomized bundles against an arithmetic reference model.
module tb_inst_encoder_loader;
    import inst_encoder_loader_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;
    localparam int BASE   = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        fmt = '0;
    logic [6:0]        opcode = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [31:0]       imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic              full;
    logic              err;
    logic [7:0]        err_count;
    logic [ADDR_W:0]   word_count;

    inst_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .full(full), .err(err),
        .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [1:0]  f;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state.
    int   m_addr  = BASE;
    int   m_words = 0;
    int   m_errs  = 0;
    bit   m_err   = 1'b0;
    logic [31:0] cur_addr, cur_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_legal(input logic [1:0] f, input logic [31:0] im);
        int s;
        s = int'(im);
        case (f)
            2'b00, 2'b10: return (s >= -2048) && (s <= 2047);
            2'b11:        return (s >= -4096) && (s <= 4094) && ((s % 2) == 0);
            default:      return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] f, input logic [6:0] opc,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] w;
        w = 32'(opc) | (32'(f3) << 12) | (32'(s1) << 15);
        case (f)
            2'b00: w = w | (32'(d) << 7) | ((im & 32'hFFF) << 20);
            2'b01: w = w | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
            2'b10: w = w | (32'(s2) << 20) | ((im & 32'h1F) << 7) | (((im >> 5) & 32'h7F) << 25);
            default: w = w | (32'(s2) << 20) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7)
                         | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
        endcase
        return w;
    endfunction

    // What the CPU's extender would recover from a packed word.
    function automatic logic [31:0] extender(input logic [31:0] w, input logic [1:0] f);
        case (f)
            2'b00:   return {{20{w[31]}}, w[31:20]};
            2'b10:   return {{20{w[31]}}, w[31:25], w[11:7]};
            2'b11:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: every committed write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mem_we && mem_ack && !clear) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), e.addr);
                check("write_data", mem_wdata, e.word);
                if (e.f != FMT_R) check("roundtrip_imm", extender(mem_wdata, e.f), e.imm);
            end
        end
    end

    task automatic model_reset();
        m_addr  = BASE;
        m_words = 0;
        m_errs  = 0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    // Presents one bundle; a legal one is left pending in WRITE for complete().
    task automatic send(input logic [1:0] f, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im, output bit legal);
        int waited;
        waited = 0;
        legal  = 1'b0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1");
            return;
        end
        check("we_before_handshake", 32'(mem_we), 32'd0);
        fmt = f; opcode = opc; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        legal = model_legal(f, im);
        if (legal) begin
            cur_addr = 32'(m_addr);
            cur_word = model_word(f, opc, f3, f7, d, s1, s2, im);
            exp_q.push_back('{addr: cur_addr, word: cur_word, f: f, imm: im});
        end else begin
            m_err = 1'b1;
            if (m_errs < 255) m_errs++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (legal) begin
            check("we_latency", 32'(mem_we), 32'd1);
            check("ready_in_write", 32'(in_ready), 32'd0);
        end else begin
            check("reject_no_we", 32'(mem_we), 32'd0);
            check("reject_err", 32'(err), 32'(m_err));
            check("reject_err_count", 32'(err_count), 32'(m_errs));
            check("reject_word_count", 32'(word_count), 32'(m_words));
            check("reject_ready", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic complete(input int delay);
        for (int i = 0; i < delay; i++) begin
            check("hold_we", 32'(mem_we), 32'd1);
            check("hold_addr", 32'(mem_addr), cur_addr);
            check("hold_wdata", mem_wdata, cur_word);
            check("hold_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        m_addr  = (m_addr + 1) % (1 << ADDR_W);
        m_words++;
        check("ack_we_drop", 32'(mem_we), 32'd0);
        check("ack_word_count", 32'(word_count), 32'(m_words));
        check("ack_addr", 32'(mem_addr), 32'(m_addr));
        check("ack_full", 32'(full), 32'(m_words == DEPTH));
        check("ack_ready", 32'(in_ready), 32'(m_words != DEPTH));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        check("clear_we", 32'(mem_we), 32'd0);
        check("clear_addr", 32'(mem_addr), 32'(BASE));
        check("clear_word_count", 32'(word_count), 32'd0);
        check("clear_err", 32'(err), 32'd0);
        check("clear_err_count", 32'(err_count), 32'd0);
        check("clear_full", 32'(full), 32'd0);
        check("clear_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic poke_full();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("full_no_we", 32'(mem_we), 32'd0);
            check("full_flag", 32'(full), 32'd1);
            check("full_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'(BASE));
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        int bnd[10] = '{2047, -2048, 2048, -2049, 4094, -4096, 4095, 4096, -4097, 3};
        case ($urandom_range(0, 3))
            0:       return 32'(int'($urandom_range(0, 4095)) - 2048);
            1:       return 32'(bnd[$urandom_range(0, 9)]);
            2:       return 32'(int'($urandom_range(0, 8191)) - 4096);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit legal;
        int d;

        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // addi x1,x0,5
        send(2'b00, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, legal);
        check("addi_word", mem_wdata, 32'h00500093);
        check("addi_addr", 32'(mem_addr), 32'd0);
        complete(1);

        // sw x2,8(x1) with a slow memory
        send(2'b10, OP_STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, legal);
        check("sw_word", mem_wdata, 32'h0020A423);
        check("sw_addr", 32'(mem_addr), 32'd1);
        complete(3);

        // beq x1,x2,-4 with a single-cycle ack
        send(2'b11, OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, legal);
        check("beq_word", mem_wdata, 32'hFE208EE3);
        complete(0);

        send(2'b11, OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, legal);
        check("odd_branch_rejected", 32'(legal), 32'd0);
        send(2'b00, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, legal);
        check("imm2048_err_count", 32'(err_count), 32'd2);

        // Fourth word fills the memory
        send(2'b01, OP_REG, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, legal);
        complete(0);
        poke_full();
        do_clear();

        // Four back-to-back single-cycle writes
        for (int i = 0; i < DEPTH; i++) begin
            send(2'b00, OP_IMM, 3'b000, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 100 - 150), legal);
            complete(0);
        end
        poke_full();
        do_clear();

        // Clear aborts a pending write; the next bundle lands at BASE
        send(2'b00, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, legal);
        send_and_abort_check();
        send(2'b10, OP_STORE, 3'b010, 7'd0, 5'd0, 5'd3, 5'd4, 32'd2047, legal);
        check("after_clear_addr", 32'(mem_addr), 32'(BASE));
        complete(2);

        // Asynchronous reset between edges while a write is pending
        send(2'b11, OP_BRANCH, 3'b001, 7'd0, 5'd0, 5'd5, 5'd6, 32'd4094, legal);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_async", 32'(in_ready), 32'd1);

        // err_count saturation
        for (int i = 0; i < 258; i++) begin
            send(2'b10, OP_STORE, 3'b000, 7'd0, 5'd0, 5'd1, 5'd1, 32'h0001_0000, legal);
        end
        check("err_count_saturated", 32'(err_count), 32'd255);
        do_clear();

        // Randomized bundles
        for (int n = 0; n < 400; n++) begin
            if (m_words == DEPTH) begin
                poke_full();
                do_clear();
            end
            send(2'($urandom_range(0, 3)), 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), rand_imm(), legal);
            if (legal) begin
                d = $urandom_range(0, 3);
                if ($urandom_range(0, 19) == 0) send_and_abort_check();
                else complete(d);
            end
        end

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic send_and_abort_check();
        check("abort_we_pending", 32'(mem_we), 32'd1);
        do_clear();
    endtask

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the CPU's immediate/operand field decoder. Takes decoded fields (format, opcode, funct, register indices, signed immediate), checks immediate range, packs a 32-bit RV32I instruction word, and writes it sequentially into instruction memory.
- Used by the test/boot path to load programs into the multi-cycle CPU's instruction memory.
- Valid/ready on the input side; write/ack on the memory side.

Parameters:
- DEPTH, 64, number of instruction words the loader may write.
- ADDR_W, 6, word-address width (≥ clog2(DEPTH)).
- BASE, 0, first word address written after reset or clear.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous: return to IDLE, address to BASE, errors cleared.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  loader can accept a bundle this cycle.
- fmt  input  2  00 I-type, 01 R-type, 10 S-type, 11 B-type (same codes as the extender's immSrc).
- opcode  input  7  instruction [6:0].
- funct3  input  3  instruction [14:12].
- funct7  input  7  instruction [31:25]; R-type only.
- rd  input  5  destination register; I/R only.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2; R/S/B only.
- imm  input  32  signed immediate (byte offset for B).
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  encoded instruction.
- mem_ack  input  1  memory accepted the write this cycle.
- full  output  1  DEPTH words written.
- err  output  1  sticky: an immediate was out of range.
- err_count  output  8  rejected bundles, saturates at 255.
- word_count  output  ADDR_W+1  words successfully written.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE. mem_we=0, mem_addr=BASE, mem_wdata=0, full=0, err=0, err_count=0, word_count=0. in_ready=1 once rst_n is released.
- States: IDLE, WRITE, FULL.
- IDLE:
  - in_ready = 1.
  - A handshake (in_valid & in_ready) with a legal immediate registers the encoded word into mem_wdata and moves to WRITE. mem_we=1 from the next cycle, so latency is 1 cycle.
  - An illegal immediate: stay in IDLE, no write, err←1, err_count+1 (saturating). The bundle counts as consumed.
- WRITE:
  - in_ready=0. mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_ack: mem_we←0, mem_addr+1, word_count+1. Go to FULL if word_count reaches DEPTH, else IDLE.
  - mem_ack asserted in the first WRITE cycle is legal (single-cycle write).
- FULL: in_ready=0, full=1. Only clear or reset leave this state. in_valid is ignored.
- clear has priority in every state, including mid-WRITE: mem_we drops the same edge (the write is aborted), then IDLE, mem_addr=BASE, word_count=0, full=0, err=0, err_count=0.
- Immediate legality:
  - I, S: imm[31:11] all equal (fits signed 12 bits).
  - B: imm[31:12] all equal and imm[0]=0.
  - R: imm is ignored and never an error.
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Round-trip invariant: feeding mem_wdata back through the CPU extender with immSrc=fmt returns the original sign-extended imm for I/S/B.
- Address arithmetic: mem_addr wraps modulo 2^ADDR_W, but FULL is reached first whenever DEPTH ≤ 2^ADDR_W − BASE.

Decomposition:
- Shared package holds:
  - format codes FMT_I=2'b00, FMT_R=2'b01, FMT_S=2'b10, FMT_B=2'b11, shared with the extender's immSrc;
  - the state enum;
  - RV32I opcode constants (OP_IMM, OP_REG, OP_STORE, OP_BRANCH).
- One combinational sub-module, inst_pack: fields in, {word, imm_ok} out. Unit-tested standalone against the extender.

Test Plan:
- I-type addi x1,x0,5 (fmt=00, opcode=0010011, rd=1, imm=5) → mem_wdata=0x00500093 at addr 0, mem_we rises the cycle after the handshake.
- S-type sw x2,8(x1) (fmt=10, opcode=0100011, f3=010, rs1=1, rs2=2, imm=8) → 0x0020A423 at addr 1. Hold mem_ack low 3 cycles → mem_we/addr/wdata stable and in_ready=0 throughout.
- B-type beq x1,x2,-4 (fmt=11, opcode=1100011, imm=−4) → 0xFE208EE3. Then imm=3 (odd) → no write, err=1, err_count=1. Then I-type imm=2048 → err_count=2, word_count unchanged.
- DEPTH=4: write 4 legal words with single-cycle acks → full=1 after the 4th ack, in_ready=0, a 5th in_valid causes no mem_we.
- clear asserted while in WRITE with mem_ack low → mem_we=0 next cycle, addr=BASE, word_count=0, err cleared; the next bundle writes addr 0.
- rst_n pulled low mid-WRITE (asynchronous, between edges) → all outputs at reset values immediately, before the next clock edge.
